// File: rtl/cordic_sincos_sched_pkg.sv
// Shared types for the CORDIC sin/cos scheduler: FSM states, the tag carried
// alongside the core pipeline, and the default core latency.
package pkg_cordic_sched;

  // Scheduler operating mode.
  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    IDLE
  } state_e;

  // Widest requester ID supported (NUM_REQ up to 8).
  localparam int unsigned MAX_ID_W = 3;

  // Preprocess register plus 16 iteration stages.
  localparam int unsigned DEFAULT_LATENCY = 17;

  // One slot of the tag pipeline that shadows the core.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/cordic_sincos_sched_rr_arb.sv
// Round-robin arbiter: searches the request vector starting one past the last
// winner, returns a one-hot grant plus its index, and moves the pointer to the
// winner only when the caller actually issues (advance strobe).
module cordic_sched_rr_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_id
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] idx;
  logic            found;

  // Pick the first requester after the pointer, wrapping around.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    found      = 1'b0;
    idx        = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = ID_W'((32'(ptr_q) + off) % NUM_REQ);
      if (!found && i_req[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        o_grant_id   = idx;
      end
    end
  end

  // Pointer resets to the last requester so requester 0 wins first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= ID_W'(NUM_REQ - 1);
    end else if (i_advance) begin
      ptr_q <= o_grant_id;
    end
  end

endmodule

// File: rtl/cordic_sincos_sched.sv
// Round-robin scheduler sharing one pipelined sin/cos CORDIC core among
// NUM_REQ requesters. A tag pipeline shadows the core so each result leaves
// on the response bus with its requester ID; consumer backpressure freezes the
// core through its pipeline enable. i_flush drains the core and reports idle.
//
// Optional build macro CORDIC_SCHED_CHECK_EN: adds a sticky o_err flag that
// fires when core done disagrees with the tag pipeline or the in-flight count
// exceeds the core latency. Without it o_err is tied low.
module cordic_sincos_sched
  import pkg_cordic_sched::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned BITS    = 16,
  parameter int unsigned STAGES  = DEFAULT_LATENCY - 1,
  parameter int unsigned LATENCY = STAGES + 1,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [NUM_REQ*BITS-1:0] i_req_theta,
  output logic [NUM_REQ-1:0]      o_req_ready,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [ID_W-1:0]         o_rsp_id,
  output logic [BITS-1:0]         o_rsp_sin,
  output logic [BITS-1:0]         o_rsp_cos,
  input  logic                    i_flush,
  output logic                    o_idle,
  output logic                    o_core_start,
  output logic [BITS-1:0]         o_core_theta,
  output logic                    o_core_pipeline_en,
  input  logic                    i_core_done,
  input  logic [BITS-1:0]         i_core_sin,
  input  logic [BITS-1:0]         i_core_cos,
  output logic                    o_err
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  state_e            state_q;
  logic              idle_q;
  tag_t              tag_q [LATENCY];
  tag_t              tag_in;
  tag_t              head;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              stall;
  logic              issue;
  logic              rsp_fire;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   grant_id;
  logic [BITS-1:0]   theta_sel;
  logic              unused_id_hi;

  assign head         = tag_q[LATENCY-1];
  assign o_rsp_valid  = head.valid;
  assign o_rsp_id     = head.id[ID_W-1:0];
  assign unused_id_hi = ^head.id;

  // Results pass straight through; the core holds them while stalled.
  assign o_rsp_sin = i_core_sin;
  assign o_rsp_cos = i_core_cos;

  assign stall              = o_rsp_valid & ~i_rsp_ready;
  assign o_core_pipeline_en = ~stall;
  assign rsp_fire           = o_rsp_valid & i_rsp_ready;

  // Reset is folded in so nothing is granted or started while held in reset.
  assign issue = i_rst_n & (state_q == RUN) & ~stall & (|i_req_valid);

  cordic_sched_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req_valid),
    .i_advance  (issue),
    .o_grant    (grant),
    .o_grant_id (grant_id)
  );

  assign o_req_ready  = issue ? grant : '0;
  assign o_core_start = issue;
  assign o_core_theta = theta_sel;
  assign o_idle       = idle_q;

  // Select the granted requester's angle for the core.
  always_comb begin
    theta_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        theta_sel = i_req_theta[k*BITS +: BITS];
      end
    end
  end

  // Tag entering the pipeline this cycle.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = issue;
    tag_in.id    = MAX_ID_W'(grant_id);
  end

  // Tag pipeline moves in lockstep with the core pipeline enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else if (o_core_pipeline_en) begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Next in-flight count: issue adds, accepted response removes.
  always_comb begin
    cnt_d = cnt_q;
    if (issue && !rsp_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!issue && rsp_fire) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // In-flight counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (o_core_pipeline_en) begin
      cnt_q <= cnt_d;
    end
  end

  // Mode FSM with registered idle flag. Drain looks at the next count so idle
  // follows the final response handshake by one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      idle_q  <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          idle_q <= 1'b0;
          if (i_flush) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_d == '0) begin
            state_q <= IDLE;
            idle_q  <= 1'b1;
          end
        end
        IDLE: begin
          if (!i_flush) begin
            state_q <= RUN;
            idle_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= RUN;
          idle_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CORDIC_SCHED_CHECK_EN
  logic err_q;
  logic err_now;

  // Done must line up with the tag head whenever the core advances.
  assign err_now = i_rst_n &
                   ((o_core_pipeline_en & (i_core_done != head.valid)) |
                    (32'(cnt_q) > LATENCY));

  // Sticky error flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_q <= 1'b0;
    end else if (err_now) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q | err_now;
`else
  logic unused_core_done;

  assign unused_core_done = i_core_done;
  assign o_err            = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_sincos_sched.sv
// Bench for cordic_sincos_sched: behavioural CORDIC core stand-in, queue-based
// reference of accepted requests, and directed plus random traffic.
module tb_cordic_sincos_sched;

  localparam int NUM_REQ = 4;
  localparam int BITS    = 16;
  localparam int LAT     = 17;
  localparam int ID_W    = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*BITS-1:0] req_theta;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [ID_W-1:0]         rsp_id;
  logic [BITS-1:0]         rsp_sin;
  logic [BITS-1:0]         rsp_cos;
  logic                    flush;
  logic                    idle;
  logic                    core_start;
  logic [BITS-1:0]         core_theta;
  logic                    core_en;
  logic                    core_done;
  logic [BITS-1:0]         core_sin;
  logic [BITS-1:0]         core_cos;
  logic                    err;
  logic                    force_done;

  always #5 clk = ~clk;

  cordic_sincos_sched dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_req_valid        (req_valid),
    .i_req_theta        (req_theta),
    .o_req_ready        (req_ready),
    .o_rsp_valid        (rsp_valid),
    .i_rsp_ready        (rsp_ready),
    .o_rsp_id           (rsp_id),
    .o_rsp_sin          (rsp_sin),
    .o_rsp_cos          (rsp_cos),
    .i_flush            (flush),
    .o_idle             (idle),
    .o_core_start       (core_start),
    .o_core_theta       (core_theta),
    .o_core_pipeline_en (core_en),
    .i_core_done        (core_done),
    .i_core_sin         (core_sin),
    .i_core_cos         (core_cos),
    .o_err              (err)
  );

  // Core stand-in: ideal sin/cos, LAT enabled cycles from start to done.
  function automatic logic [15:0] fx_trig(input logic [15:0] th, input bit is_sin);
    real a;
    a = $itor($signed(th)) / 4096.0;
    return is_sin ? 16'(int'($sin(a) * 16384.0)) : 16'(int'($cos(a) * 16384.0));
  endfunction

  logic        cv [LAT];
  logic [15:0] cs [LAT];
  logic [15:0] cc [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        cv[i] <= 1'b0;
        cs[i] <= '0;
        cc[i] <= '0;
      end
    end else if (core_en) begin
      cv[0] <= core_start;
      cs[0] <= fx_trig(core_theta, 1'b1);
      cc[0] <= fx_trig(core_theta, 1'b0);
      for (int i = 1; i < LAT; i++) begin
        cv[i] <= cv[i-1];
        cs[i] <= cs[i-1];
        cc[i] <= cc[i-1];
      end
    end
  end

  assign core_done = cv[LAT-1] | force_done;
  assign core_sin  = cs[LAT-1];
  assign core_cos  = cc[LAT-1];

  // Reference state.
  typedef struct {
    int          id;
    logic [15:0] theta;
    int          acc_cyc;
    int          acc_stalls;
  } exp_t;

  exp_t q[$];
  int   grant_log[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   stalls = 0;
  int   accepts = 0;
  int   last_grant = NUM_REQ - 1;
  int   gmode = 0;
  logic err_expect = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic signed [15:0] obs, input real ref_v);
    real d;
    d = $itor(obs) - ref_v;
    if (d < 0.0) d = -d;
    total++;
    assert (d <= 4.0) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d(+-4)", tag, obs, int'(ref_v));
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    int idx;
    for (int o = 1; o <= NUM_REQ; o++) begin
      idx = (last + o) % NUM_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [15:0] rand_theta();
    int t;
    t = int'($urandom_range(0, 12868)) - 6434;
    return 16'(t);
  endfunction

  task automatic set_thetas();
    for (int k = 0; k < NUM_REQ; k++) req_theta[k*BITS +: BITS] = rand_theta();
  endtask

  // Per-cycle observation at the falling edge.
  task automatic sample();
    logic stalled;
    int   eg;
    exp_t e;
    real  a;
    stalled = rsp_valid && !rsp_ready;
    chk("pipeline_en", core_en, !stalled);
    chk("err", err, err_expect);
    if (gmode == 1 && rst_n && !stalled && (|req_valid)) begin
      eg = rr_pick(req_valid, last_grant);
      chk("grant", req_ready, 64'(1 << eg));
      chk("core_start", core_start, 1);
    end else begin
      chk("no_grant", req_ready, 0);
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid[k] && req_ready[k]) begin
        e.id         = k;
        e.theta      = req_theta[k*BITS +: BITS];
        e.acc_cyc    = cyc;
        e.acc_stalls = stalls;
        q.push_back(e);
        grant_log.push_back(k);
        last_grant = k;
        accepts++;
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        chk("spurious_rsp", rsp_valid, 0);
      end else begin
        e = q.pop_front();
        a = $itor($signed(e.theta)) / 4096.0;
        chk("rsp_id", rsp_id, e.id);
        chk_near("rsp_sin", rsp_sin, $sin(a) * 16384.0);
        chk_near("rsp_cos", rsp_cos, $cos(a) * 16384.0);
        chk("latency", cyc - e.acc_cyc, LAT + stalls - e.acc_stalls);
      end
    end
    if (stalled) stalls++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n;
    req_valid = '0;
    rsp_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_left", q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    int          n;
    int          acc0;
    int          exp_seq [8];
    logic [15:0] cap_sin;
    logic [15:0] cap_cos;
    logic [1:0]  cap_id;

    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    rst_n      = 1'b0;
    req_valid  = '1;
    set_thetas();
    rsp_ready  = 1'b1;
    flush      = 1'b0;
    force_done = 1'b0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_start", core_start, 0);
    chk("rst_pipe_en", core_en, 1);
    chk("rst_idle", idle, 0);
    chk("rst_err", err, 0);
    tick();
    tick();
    req_valid = '0;
    rst_n     = 1'b1;
    gmode     = 1;
    tick();

    // Fairness: everybody requesting for 8 cycles.
    grant_log.delete();
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      set_thetas();
      tick();
    end
    req_valid = '0;
    for (int i = 0; i < 8; i++) begin
      chk("fair_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_seq[i]);
    end
    drain();

    // Single request at pi/2 from requester 2.
    req_theta[2*BITS +: BITS] = 16'h1922;
    req_valid = 4'b0100;
    acc0 = accepts;
    tick();
    chk("single_accept", accepts - acc0, 1);
    acc0 = cyc - 1;
    req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("single_latency", cyc - acc0, LAT);
    chk("single_id", rsp_id, 2);
    chk_near("single_sin", rsp_sin, 16384.0);
    chk_near("single_cos", rsp_cos, 0.0);
    drain();

    // Backpressure while a response is waiting.
    for (int i = 0; i < 6; i++) begin
      req_valid = NUM_REQ'($urandom);
      set_thetas();
      tick();
    end
    rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      req_valid = NUM_REQ'($urandom);
      set_thetas();
      tick();
      n++;
    end
    chk("bp_rsp_seen", rsp_valid, 1);
    cap_sin = rsp_sin;
    cap_cos = rsp_cos;
    cap_id  = rsp_id;
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_pipe_en", core_en, 0);
      chk("bp_ready", req_ready, 0);
      chk("bp_sin_hold", rsp_sin, cap_sin);
      chk("bp_cos_hold", rsp_cos, cap_cos);
      chk("bp_id_hold", rsp_id, cap_id);
    end
    drain();

    // Random traffic with random consumer readiness.
    for (int i = 0; i < 200; i++) begin
      req_valid = NUM_REQ'($urandom);
      set_thetas();
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Flush after six requests.
    acc0 = accepts;
    n = 0;
    while (accepts - acc0 < 6 && n < 100) begin
      req_valid = NUM_REQ'($urandom);
      set_thetas();
      tick();
      n++;
    end
    chk("flush_six", accepts - acc0, 6);
    req_valid = '0;
    flush = 1'b1;
    tick();
    gmode = 0;
    req_valid = '1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      chk("idle_busy", idle, 0);
      tick();
      n++;
    end
    chk("idle_rise", idle, 1);
    repeat (3) begin
      tick();
      chk("idle_hold", idle, 1);
    end
    flush = 1'b0;
    tick();
    gmode = 1;
    #1;
    chk("flush_resume", req_ready != 0, 1);
    tick();
    chk("idle_fall", idle, 0);
    drain();

    // Reset with ten requests in flight and a response pending.
    acc0 = accepts;
    n = 0;
    req_valid = '1;
    while (accepts - acc0 < 10 && n < 40) begin
      set_thetas();
      tick();
      n++;
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk("rst_mid_pending", rsp_valid, 1);
    #1;
    rst_n = 1'b0;
    gmode = 0;
    q.delete();
    last_grant = NUM_REQ - 1;
    #1;
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_pipe_en", core_en, 1);
    tick();
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    gmode = 1;
    for (int i = 0; i < 25; i++) begin
      tick();
      chk("no_stale", rsp_valid, 0);
    end
    req_valid = '1;
    set_thetas();
    #1;
    chk("first_after_rst", req_ready, 4'b0001);
    tick();
    drain();

`ifdef CORDIC_SCHED_CHECK_EN
    // Done with an empty tag pipeline must raise the sticky error.
    force_done = 1'b1;
    #1;
    chk("err_set", err, 1);
    err_expect = 1'b1;
    tick();
    force_done = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    gmode = 0;
    err_expect = 1'b0;
    #1;
    chk("err_clear", err, 0);
    tick();
    rst_n = 1'b1;
    gmode = 1;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_sincos_sched.md
Name: cordic_sincos_sched

Overview:
- Round-robin scheduler that shares one pipelined sin/cos CORDIC core among NUM_REQ requesters.
- Issues at most one angle per cycle into the core and carries a requester-ID tag alongside the pipeline.
- Returns each result on a shared response bus tagged with its ID, and stalls the core through its pipeline-enable when the consumer backpressures.
- Provides a drain/flush mode so software can quiesce the core before a reconfiguration.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BITS, 16, core datapath width; theta is signed with the upper 4 bits integer, sin/cos signed with the upper 2 bits integer.
- STAGES, 16, number of core iteration stages.
- LATENCY, STAGES+1, core cycles from start to done while pipeline-enable is held high (preprocess register plus STAGES).
- ID_W, $clog2(NUM_REQ), tag width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- i_req_theta  in  NUM_REQ*BITS  flattened angles; requester k occupies [k*BITS +: BITS].
- o_req_ready  out  NUM_REQ  one-hot grant; the request is accepted on valid&ready.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  consumer ready.
- o_rsp_id  out  ID_W  requester ID of the current response.
- o_rsp_sin  out  BITS  sin result.
- o_rsp_cos  out  BITS  cos result.
- i_flush  in  1  level request: stop accepting requests and drain the core.
- o_idle  out  1  high when no work is in flight and the scheduler is not accepting (flush complete).
- o_core_start  out  1  core start.
- o_core_theta  out  BITS  core angle input.
- o_core_pipeline_en  out  1  core pipeline enable.
- i_core_done  in  1  core done.
- i_core_sin  in  BITS  core sin output.
- i_core_cos  in  BITS  core cos output.
- o_err  out  1  sticky tag/done mismatch flag (optional feature).

Behaviour:
Reset values:
- i_rst_n low asynchronously clears the tag pipeline, in-flight counter, round-robin pointer (pointer = NUM_REQ-1, so requester 0 has first priority) and o_err; state = RUN.
- Outputs during reset: o_req_ready=0, o_rsp_valid=0, o_core_start=0, o_core_pipeline_en=1, o_idle=0.
- The core shares i_rst_n.
- Reset mid-operation discards all in-flight results; no response is emitted for them.

Stall:
- stall = o_rsp_valid & ~i_rsp_ready.
- o_core_pipeline_en = ~stall. The path from i_rsp_ready to pipeline-enable is combinational.
- The tag pipeline and in-flight counter advance only when o_core_pipeline_en is high.

Tag pipeline:
- LATENCY entries of {valid, id}.
- Entry 0 loads {issue, grant_id}; entry n loads entry n-1.
- o_rsp_valid = tag[LATENCY-1].valid; o_rsp_id = tag[LATENCY-1].id.
- o_rsp_sin and o_rsp_cos pass through from the core unregistered. The core holds its outputs while stalled, so the response stays stable under backpressure.

Arbitration:
- Round-robin over i_req_valid, starting at pointer+1.
- issue = state==RUN & ~stall & |i_req_valid.
- o_req_ready is the one-hot grant gated by issue; ready may depend on valid.
- On issue: o_core_start=1, o_core_theta = selected theta, pointer = grant_id.
- The pointer is unchanged on cycles with no issue.
- Throughput: one request per cycle when unstalled. Issue-to-response latency is LATENCY cycles plus stall cycles.

In-flight counter:
- Width $clog2(LATENCY+1).
- +1 on issue, -1 on o_rsp_valid&i_rsp_ready; both events in one cycle leave it unchanged.
- Saturation is impossible: the count is at most LATENCY by construction.

State machine (pkg state_e):
- RUN: normal operation. i_flush=1 -> DRAIN, effective the next cycle; the issue that coincides with the flush-assert cycle is still accepted.
- DRAIN: no grants. When in-flight==0 -> IDLE.
- IDLE: o_idle=1, no grants. When i_flush=0 -> RUN.
- If i_flush drops while in DRAIN, the scheduler finishes draining, passes through IDLE for exactly one cycle, then returns to RUN.

Optional Feature:
- Macro CORDIC_SCHED_CHECK_EN.
- When defined: each cycle with o_core_pipeline_en=1 compares i_core_done against tag[LATENCY-1].valid. Any mismatch sets o_err, which is sticky until reset. Also checks that in-flight never exceeds LATENCY, setting o_err on violation.
- When undefined: o_err is tied 0 and no comparison logic is built.

Decomposition:
- Package pkg_cordic_sched holds:
  - typedef enum state_e {RUN, DRAIN, IDLE};
  - packed struct tag_t {logic valid; logic [ID_W-1:0] id;}, parameterised via localparam MAX_ID_W=3;
  - localparam DEFAULT_LATENCY = 17.
- Sub-module cordic_sched_rr_arb contains the round-robin arbiter: request vector in, advance strobe in, one-hot grant and grant_id out, pointer register internal.

Test Plan:
- Single request: requester 2 theta=0x1922 (pi/2, BITS=16) -> o_rsp_valid exactly 17 cycles after accept, id=2, sin≈0x4000 (±4 LSB), cos≈0x0000 (±4 LSB).
- Fairness: all 4 valid continuously for 8 cycles -> grants in order 0,1,2,3,0,1,2,3, and responses return in the same ID order.
- Backpressure: i_rsp_ready=0 for 5 cycles while a response is valid -> pipeline_en=0, no new grants, o_rsp_sin/cos/id unchanged; after release, all responses delivered with none lost or duplicated.
- Flush: 6 requests issued, then i_flush=1 -> no further grants, o_idle rises one cycle after the 6th response; i_flush=0 -> grants resume.
- Reset mid-flight: i_rst_n low with 10 in flight -> o_rsp_valid=0 immediately, no stale responses after release, requester 0 granted first.
- CHECK_EN: force i_core_done=1 with an empty tag pipeline -> o_err=1 the same cycle and stays 1 until reset.
